// File: rtl/x3q16_exec_stage_if.sv
// Handshake bundle between decode, the execute stage and writeback.
// Optional forwarding selects appear when X3Q16_EXEC_FWD_EN is defined.
interface x3q16_exec_stage_if;
    // Decode -> execute
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_mode;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_rd;
`ifdef X3Q16_EXEC_FWD_EN
    logic        in_fwd_a;
    logic        in_fwd_b;
`endif
    // Execute -> writeback
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    // Compare flags
    logic        flag_eq;
    logic        flag_gt;

    // Driver side: decode plus writeback
    modport master (
        output in_valid,
        output in_mode,
        output in_a,
        output in_b,
        output in_rd,
`ifdef X3Q16_EXEC_FWD_EN
        output in_fwd_a,
        output in_fwd_b,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_rd,
        input  flag_eq,
        input  flag_gt
    );

    // Execute stage side
    modport slave (
        input  in_valid,
        input  in_mode,
        input  in_a,
        input  in_b,
        input  in_rd,
`ifdef X3Q16_EXEC_FWD_EN
        input  in_fwd_a,
        input  in_fwd_b,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_rd,
        output flag_eq,
        output flag_gt
    );
endinterface

// File: rtl/x3q16_exec_stage.sv
// Two-register execute stage: S1 captures the operation, S2 holds the ALU
// result for writeback. Compare flags update only when a subtract moves into S2.
// Optional operand forwarding from the last retired result: define X3Q16_EXEC_FWD_EN.
module x3q16_exec_stage (
    input  logic                clk,
    input  logic                rst_n,
    x3q16_exec_stage_if.slave   bus
);
    localparam logic [2:0] ModeAdd  = 3'b000;
    localparam logic [2:0] ModeSub  = 3'b001;
    localparam logic [2:0] ModeMul  = 3'b010;
    localparam logic [2:0] ModeNand = 3'b011;
    localparam logic [2:0] ModeShl  = 3'b100;
    localparam logic [2:0] ModeShr  = 3'b101;

    // S1 state
    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_mode_q,  s1_mode_d;
    logic [15:0] s1_a_q,     s1_a_d;
    logic [15:0] s1_b_q,     s1_b_d;
    logic [2:0]  s1_rd_q,    s1_rd_d;
    // S2 state
    logic        s2_valid_q,  s2_valid_d;
    logic [15:0] s2_result_q, s2_result_d;
    logic [2:0]  s2_rd_q,     s2_rd_d;
    logic        flag_eq_q,   flag_eq_d;
    logic        flag_gt_q,   flag_gt_d;

    logic        accept;
    logic        s1_move;
    logic        retire;
    logic [15:0] opnd_a;
    logic [15:0] opnd_b;
    logic [15:0] mul_full;
    logic [15:0] alu_result;
    logic        cmp_eq;
    logic        cmp_gt;

    assign retire      = s2_valid_q & bus.out_ready;
    assign s1_move     = s1_valid_q & (~s2_valid_q | bus.out_ready);
    assign bus.in_ready = ~s1_valid_q | ~s2_valid_q | bus.out_ready;
    assign accept      = bus.in_valid & bus.in_ready;

`ifdef X3Q16_EXEC_FWD_EN
    logic [15:0] last_q, last_d;
    logic [15:0] fwd_value;

    // A result retiring this cycle is newer than the stored copy
    always_comb begin
        fwd_value = retire ? s2_result_q : last_q;
        opnd_a    = bus.in_fwd_a ? fwd_value : bus.in_a;
        opnd_b    = bus.in_fwd_b ? fwd_value : bus.in_b;
        last_d    = retire ? s2_result_q : last_q;
    end

    // Last retired result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 16'h0000;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Operands come straight from decode
    always_comb begin
        opnd_a = bus.in_a;
        opnd_b = bus.in_b;
    end
`endif

    // ALU and comparator on S1 contents
    always_comb begin
        mul_full   = {8'h00, s1_a_q[7:0]} * {8'h00, s1_b_q[7:0]};
        cmp_eq     = (s1_a_q == s1_b_q);
        cmp_gt     = ($signed(s1_a_q) > $signed(s1_b_q));
        alu_result = 16'h0000;
        case (s1_mode_q)
            ModeAdd:  alu_result = s1_a_q + s1_b_q;
            ModeSub:  alu_result = s1_a_q - s1_b_q;
            ModeMul:  alu_result = {7'h00, mul_full[8:0]};
            ModeNand: alu_result = ~(s1_a_q & s1_b_q);
            ModeShl:  alu_result = {s1_a_q[14:0], 1'b0};
            ModeShr:  alu_result = {1'b0, s1_a_q[15:1]};
            default:  alu_result = 16'h0000;
        endcase
    end

    // S1 next state: load on accept, empty when it drains into S2
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_rd_d    = s1_rd_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_mode_d  = bus.in_mode;
            s1_a_d     = opnd_a;
            s1_b_d     = opnd_b;
            s1_rd_d    = bus.in_rd;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 next state: payload changes only on a move, so it holds while stalled
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_rd_d     = s2_rd_q;
        flag_eq_d   = flag_eq_q;
        flag_gt_d   = flag_gt_q;
        if (s1_move) begin
            s2_valid_d  = 1'b1;
            s2_result_d = alu_result;
            s2_rd_d     = s1_rd_q;
            if (s1_mode_q == ModeSub) begin
                flag_eq_d = cmp_eq;
                flag_gt_d = cmp_gt;
            end
        end else if (retire) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 3'b000;
            s1_a_q      <= 16'h0000;
            s1_b_q      <= 16'h0000;
            s1_rd_q     <= 3'b000;
            s2_valid_q  <= 1'b0;
            s2_result_q <= 16'h0000;
            s2_rd_q     <= 3'b000;
            flag_eq_q   <= 1'b0;
            flag_gt_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_rd_q     <= s1_rd_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_rd_q     <= s2_rd_d;
            flag_eq_q   <= flag_eq_d;
            flag_gt_q   <= flag_gt_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_rd     = s2_rd_q;
    assign bus.flag_eq    = flag_eq_q;
    assign bus.flag_gt    = flag_gt_q;
endmodule

// File: tb/tb_x3q16_exec_stage.sv
// Scoreboard bench for x3q16_exec_stage: accepted operations are modelled and
// queued; a monitor compares every presented output against the queue head.
`timescale 1ns/1ps
module tb_x3q16_exec_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    x3q16_exec_stage_if ifc();

    x3q16_exec_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic [15:0] res;
        logic [2:0]  rd;
        logic        eq;
        logic        gt;
        int          acc;
        bit          lat;
        bit          seen;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rdy_mode = 1;
    bit          lat_chk = 0;
    bit          fl_eq_m = 0;
    bit          fl_gt_m = 0;
    logic [15:0] last_model = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = held low, 1 = held high, otherwise random
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       ifc.out_ready = 1'b0;
            1:       ifc.out_ready = 1'b1;
            default: ifc.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sgn(input logic [15:0] v);
        return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
    endfunction

    // Reference ALU in plain integer arithmetic
    function automatic logic [15:0] ref_alu(input logic [2:0] m, input logic [15:0] a,
                                            input logic [15:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (m)
            3'd0:    return 16'((ia + ib) % 65536);
            3'd1:    return 16'((ia - ib + 65536) % 65536);
            3'd2:    return 16'(((ia % 256) * (ib % 256)) % 512);
            3'd3:    return 16'(65535 - (ia & ib));
            3'd4:    return 16'((ia * 2) % 65536);
            3'd5:    return 16'(ia / 2);
            default: return 16'h0000;
        endcase
    endfunction

    // Acceptance tracker: model each accepted op and queue its expected output
    always @(negedge clk) begin : trk
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;
        #1;
        if (!rst_n) begin
            fl_eq_m = 1'b0;
            fl_gt_m = 1'b0;
        end else if (ifc.in_valid === 1'b1 && ifc.in_ready === 1'b1) begin
            a = ifc.in_a;
            b = ifc.in_b;
`ifdef X3Q16_EXEC_FWD_EN
            if (ifc.in_fwd_a) a = last_model;
            if (ifc.in_fwd_b) b = last_model;
`endif
            if (ifc.in_mode == 3'd1) begin
                fl_eq_m = (a == b);
                fl_gt_m = (sgn(a) > sgn(b));
            end
            e.res  = ref_alu(ifc.in_mode, a, b);
            e.rd   = ifc.in_rd;
            e.eq   = fl_eq_m;
            e.gt   = fl_gt_m;
            e.acc  = cyc;
            e.lat  = lat_chk;
            e.seen = 0;
            sbq.push_back(e);
        end
    end

    // Output monitor: compare whatever the stage presents, pop on handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            last_model = 16'h0000;
        end else if (ifc.out_valid !== 1'b0) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out: got out_valid=%b result=%h rd=%0d, expected no output",
                         ifc.out_valid, ifc.out_result, ifc.out_rd);
            end else begin
                if (!sbq[0].seen) begin
                    sbq[0].seen = 1;
                    if (sbq[0].lat) check("latency", cyc - sbq[0].acc, 2);
                end
                check("out_result", ifc.out_result, sbq[0].res);
                check("out_rd", ifc.out_rd, sbq[0].rd);
                check("flag_eq", ifc.flag_eq, sbq[0].eq);
                check("flag_gt", ifc.flag_gt, sbq[0].gt);
                if (ifc.out_ready === 1'b1) begin
                    last_model = sbq[0].res;
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic present(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] rd, input logic fa, input logic fb);
        ifc.in_valid = 1'b1;
        ifc.in_mode  = m;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_rd    = rd;
`ifdef X3Q16_EXEC_FWD_EN
        ifc.in_fwd_a = fa;
        ifc.in_fwd_b = fb;
`endif
    endtask

    // Present an op and hold it until accepted; returns just after the accepting edge
    task automatic send_op(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] rd, input logic fa, input logic fb);
        int n;
        n = 0;
        present(m, a, b, rd, fa, fb);
        @(negedge clk);
        while (ifc.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=%b, expected 1 within 200 cycles",
                     ifc.in_ready);
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_mode  = 3'd0;
        ifc.in_a     = 16'h0;
        ifc.in_b     = 16'h0;
        ifc.in_rd    = 3'd0;
`ifdef X3Q16_EXEC_FWD_EN
        ifc.in_fwd_a = 1'b0;
        ifc.in_fwd_b = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_result", ifc.out_result, 0);
        check("rst_out_rd", ifc.out_rd, 0);
        check("rst_flag_eq", ifc.flag_eq, 0);
        check("rst_flag_gt", ifc.flag_gt, 0);
        check("rst_in_ready", ifc.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed ops with out_ready held high, latency checked
        lat_chk = 1;
        send_op(3'd0, 16'h7FFF, 16'h0001, 3'd3, 0, 0);
        send_op(3'd1, 16'hFFFE, 16'h0003, 3'd1, 0, 0);
        send_op(3'd1, 16'h0005, 16'h0005, 3'd2, 0, 0);
        send_op(3'd1, 16'h0003, 16'hFFFF, 3'd4, 0, 0);
        send_op(3'd2, 16'h00FF, 16'h00FF, 3'd5, 0, 0);
        send_op(3'd3, 16'hFFFF, 16'hFFFF, 3'd6, 0, 0);
        send_op(3'd7, 16'h1234, 16'h5678, 3'd7, 0, 0);
        send_op(3'd4, 16'h8001, 16'h0000, 3'd0, 0, 0);
        send_op(3'd5, 16'h8001, 16'h0000, 3'd1, 0, 0);
        drain();
        lat_chk = 0;

        // Backpressure: two accepts fill the pipe, then in_ready must stay low
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_op(3'd0, 16'h0010, 16'h0001, 3'd1, 0, 0);
        send_op(3'd0, 16'h0020, 16'h0002, 3'd2, 0, 0);
        present(3'd1, 16'h0030, 16'h0003, 3'd3, 0, 0);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", ifc.in_ready, 0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send_op(3'd1, 16'h0030, 16'h0003, 3'd3, 0, 0);
        send_op(3'd2, 16'h0040, 16'h0004, 3'd4, 0, 0);
        drain();

        // Reset with both stages full and flags set
        send_op(3'd1, 16'h0005, 16'h0005, 3'd5, 0, 0);
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_op(3'd0, 16'h0001, 16'h0001, 3'd6, 0, 0);
        send_op(3'd0, 16'h0002, 16'h0002, 3'd7, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", ifc.out_valid, 0);
        check("midrst_flag_eq", ifc.flag_eq, 0);
        check("midrst_flag_gt", ifc.flag_gt, 0);
        check("midrst_in_ready", ifc.in_ready, 1);
        rdy_mode = 1;
        repeat (6) @(negedge clk);

`ifdef X3Q16_EXEC_FWD_EN
        @(posedge clk);
        #1;
        send_op(3'd0, 16'h0002, 16'h0003, 3'd1, 0, 0);
        drain();
        send_op(3'd0, 16'h0000, 16'h0001, 3'd2, 1, 0);
        drain();
`endif

        // Randomized traffic with random backpressure
        rdy_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            send_op(3'($urandom_range(0, 7)), ra, rb, 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/x3q16_exec_stage.md
X3Q16_EXEC_STAGE -- requirements
Module: x3q16_exec_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, decode presents an operation.
REQ-004 SHALL have port in_ready, output, 1, stage accepts the operation this cycle.
REQ-005 SHALL have port in_mode, input, 3, ALU mode.
REQ-006 SHALL have port in_a, input, 16, operand A.
REQ-007 SHALL have port in_b, input, 16, operand B.
REQ-008 SHALL have port in_rd, input, 3, destination register index.
REQ-009 SHALL have port out_valid, output, 1, result available to writeback.
REQ-010 SHALL have port out_ready, input, 1, writeback consumes the result.
REQ-011 SHALL have port out_result, output, 16, ALU result.
REQ-012 SHALL have port out_rd, output, 3, destination register index carried with the result.
REQ-013 SHALL have port flag_eq, output, 1, registered equal flag.
REQ-014 SHALL have port flag_gt, output, 1, registered signed A>B flag.

Function
REQ-015 SHALL be a two-register pipeline: S1 holds mode/a/b/rd/valid; S2 holds result/rd/valid, driving out_*.
REQ-016 SHALL accept an operation when in_valid & in_ready; in_ready = !s1_valid | (!s2_valid | out_ready).
REQ-017 SHALL move S1 into S2 when s1_valid & (!s2_valid | out_ready); S2 clears when out_ready & !s1_valid.
REQ-018 SHALL produce out_valid exactly 2 cycles after acceptance when out_ready stays high; throughput 1 op/cycle.
REQ-019 SHALL hold out_result/out_rd stable while out_valid & !out_ready; no operation lost or duplicated.
REQ-020 SHALL compute the result on S1 contents: 000 a+b, 001 a-b, 010 zero-extended low 9 bits of a[7:0]*b[7:0], 011 ~(a&b), 100 a<<1, 101 a>>1 (logical), 110/111 16'h0000; all add/sub mod 2^16.
REQ-021 SHALL update flag_eq/flag_gt only when a mode-001 op moves S1->S2: flag_eq = (a==b), flag_gt = (a>b, signed two's complement); other modes leave flags unchanged.
REQ-022 SHALL ignore in_mode/in_a/in_b/in_rd when in_valid is low or in_ready is low.

Reset
REQ-023 SHALL on clk edge with rst_n low clear s1_valid, s2_valid, out_result, out_rd, flag_eq, flag_gt to 0; in_ready reads 1 in the first cycle after reset.
REQ-024 SHALL discard any in-flight operations when reset is asserted mid-operation; no out_valid pulse for them.

Configuration
REQ-025 SHALL, with macro X3Q16_EXEC_FWD_EN defined, add inputs in_fwd_a and in_fwd_b (1 bit each) and a 16-bit last-result register (reset 0) loaded with out_result on every out_valid & out_ready.
REQ-026 SHALL, with X3Q16_EXEC_FWD_EN defined, substitute the last-result register for in_a (in_b) at acceptance when in_fwd_a (in_fwd_b) is 1; a retirement in the same cycle forwards the retiring out_result.
REQ-027 SHALL, without X3Q16_EXEC_FWD_EN, omit those ports and register and use in_a/in_b directly.

Verification
REQ-028 SHALL pass: reset, then mode 000 a=16'h7FFF b=16'h0001 rd=3, out_ready=1 -> out_valid 2 cycles later, out_result=16'h8000, out_rd=3.
REQ-029 SHALL pass: mode 001 a=16'hFFFE(-2) b=16'h0003 -> out_result=16'hFFFB, flag_eq=0, flag_gt=0; then a=5 b=5 -> flag_eq=1, flag_gt=0; then a=3 b=16'hFFFF -> flag_gt=1.
REQ-030 SHALL pass: mode 010 a=16'h00FF b=16'h00FF -> out_result=16'h0001; mode 011 a=b=16'hFFFF -> 16'h0000; mode 111 -> 16'h0000; flags unchanged.
REQ-031 SHALL pass: 4 back-to-back ops with out_ready held low for 5 cycles -> in_ready falls after 2 accepts, out_result stable; on release all 4 retire in order, one per cycle.
REQ-032 SHALL pass: rst_n low for 1 cycle with both stages full -> out_valid=0, flags=0 next cycle, no stale result emitted afterwards.
REQ-033 SHALL pass (X3Q16_EXEC_FWD_EN): op1 000 a=2 b=3 retires 5; op2 000 in_fwd_a=1 b=1 -> out_result=16'h0006.
